// File: rtl/rob_pkg.sv
// Shared types and default sizes for the 2-wide reorder-buffer commit controller.
package rob_pkg;

    localparam int ROB_QUEUE_SIZE = 64;
    localparam int ROB_NUM_P_REGS = 64;
    localparam int ROB_PC_SIZE    = 32;
    localparam int IDX_W          = $clog2(ROB_QUEUE_SIZE);
    localparam int PREG_W         = $clog2(ROB_NUM_P_REGS);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_e;

    typedef struct packed {
        logic valid;
        logic complete;
        logic exc;
    } rob_status_t;

    // Number of set strobes among a pair of slot enables.
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch / completion / commit / flush bus between the pipeline and the ROB commit controller.
interface rob_commit_ctrl_if #(
    parameter int IDX_W   = rob_pkg::IDX_W,
    parameter int PREG_W  = rob_pkg::PREG_W,
    parameter int PC_SIZE = rob_pkg::ROB_PC_SIZE
);
    logic               alloc_req0_i;
    logic               alloc_req1_i;
    logic               alloc_gnt0_o;
    logic               alloc_gnt1_o;
    logic [IDX_W-1:0]   alloc_idx0_o;
    logic [IDX_W-1:0]   alloc_idx1_o;
    logic               rob_full_o;
    logic               cmpl_en0_i;
    logic               cmpl_en1_i;
    logic [IDX_W-1:0]   cmpl_idx0_i;
    logic [IDX_W-1:0]   cmpl_idx1_i;
    logic               cmpl_exc0_i;
    logic               cmpl_exc1_i;
    logic [IDX_W-1:0]   commit_idx0_o;
    logic [IDX_W-1:0]   commit_idx1_o;
    logic [PREG_W-1:0]  rob_old_dest0_i;
    logic [PREG_W-1:0]  rob_old_dest1_i;
    logic [PC_SIZE-1:0] rob_pc0_i;
    logic               freelist_rdy_i;
    logic               commit_en0_o;
    logic               commit_en1_o;
    logic               free_en0_o;
    logic               free_en1_o;
    logic [PREG_W-1:0]  free_preg0_o;
    logic [PREG_W-1:0]  free_preg1_o;
    logic               flush_o;
    logic [PC_SIZE-1:0] redirect_pc_o;

    modport slave (
        input  alloc_req0_i, alloc_req1_i,
        output alloc_gnt0_o, alloc_gnt1_o, alloc_idx0_o, alloc_idx1_o, rob_full_o,
        input  cmpl_en0_i, cmpl_en1_i, cmpl_idx0_i, cmpl_idx1_i, cmpl_exc0_i, cmpl_exc1_i,
        output commit_idx0_o, commit_idx1_o,
        input  rob_old_dest0_i, rob_old_dest1_i, rob_pc0_i, freelist_rdy_i,
        output commit_en0_o, commit_en1_o, free_en0_o, free_en1_o,
        output free_preg0_o, free_preg1_o, flush_o, redirect_pc_o
    );

    modport master (
        output alloc_req0_i, alloc_req1_i,
        input  alloc_gnt0_o, alloc_gnt1_o, alloc_idx0_o, alloc_idx1_o, rob_full_o,
        output cmpl_en0_i, cmpl_en1_i, cmpl_idx0_i, cmpl_idx1_i, cmpl_exc0_i, cmpl_exc1_i,
        input  commit_idx0_o, commit_idx1_o,
        output rob_old_dest0_i, rob_old_dest1_i, rob_pc0_i, freelist_rdy_i,
        input  commit_en0_o, commit_en1_o, free_en0_o, free_en1_o,
        input  free_preg0_o, free_preg1_o, flush_o, redirect_pc_o
    );

endinterface

// File: rtl/rob_status_array.sv
// Per-entry valid/complete/exc bits of the ROB. Write priority, lowest to highest:
// completion, commit clear, allocation, bulk clear. Two completions to one entry OR their flags.
module rob_status_array
    import rob_pkg::*;
#(
    parameter int QUEUE_SIZE = ROB_QUEUE_SIZE
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          alloc_we0_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] alloc_idx0_i,
    input  logic                          alloc_we1_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] alloc_idx1_i,
    input  logic                          cmpl_we0_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] cmpl_idx0_i,
    input  logic                          cmpl_exc0_i,
    input  logic                          cmpl_we1_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] cmpl_idx1_i,
    input  logic                          cmpl_exc1_i,
    input  logic                          clr_we0_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] clr_idx0_i,
    input  logic                          clr_we1_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] clr_idx1_i,
    input  logic                          bulk_clr_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] rd_idx0_i,
    input  logic [$clog2(QUEUE_SIZE)-1:0] rd_idx1_i,
    output rob_status_t                   rd_st0_o,
    output rob_status_t                   rd_st1_o,
    output logic [QUEUE_SIZE-1:0]         valid_vec_o
);

    rob_status_t stat_q [QUEUE_SIZE];
    rob_status_t stat_d [QUEUE_SIZE];

    // Merge all write ports into the next array image.
    always_comb begin
        stat_d = stat_q;
        if (cmpl_we0_i) begin
            stat_d[cmpl_idx0_i].complete = 1'b1;
            stat_d[cmpl_idx0_i].exc      = stat_d[cmpl_idx0_i].exc | cmpl_exc0_i;
        end
        if (cmpl_we1_i) begin
            stat_d[cmpl_idx1_i].complete = 1'b1;
            stat_d[cmpl_idx1_i].exc      = stat_d[cmpl_idx1_i].exc | cmpl_exc1_i;
        end
        if (clr_we0_i) stat_d[clr_idx0_i].valid = 1'b0;
        if (clr_we1_i) stat_d[clr_idx1_i].valid = 1'b0;
        if (alloc_we0_i) stat_d[alloc_idx0_i] = '{valid: 1'b1, complete: 1'b0, exc: 1'b0};
        if (alloc_we1_i) stat_d[alloc_idx1_i] = '{valid: 1'b1, complete: 1'b0, exc: 1'b0};
        if (bulk_clr_i) begin
            for (int i = 0; i < QUEUE_SIZE; i++) stat_d[i] = '0;
        end
    end

    // Status storage, cleared on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < QUEUE_SIZE; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    // Head-side read ports and the valid vector used to filter completions.
    always_comb begin
        rd_st0_o = stat_q[rd_idx0_i];
        rd_st1_o = stat_q[rd_idx1_i];
        for (int i = 0; i < QUEUE_SIZE; i++) valid_vec_o[i] = stat_q[i].valid;
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB sequencing controller: head/tail/count, dispatch grants, completion tracking,
// in-order 2-wide retirement and one-cycle exception flush.
// Optional performance counters are built when ROB_PERF_CNT_EN is defined.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int QUEUE_SIZE = ROB_QUEUE_SIZE,
    parameter int NUM_P_REGS = ROB_NUM_P_REGS,
    parameter int PC_SIZE    = ROB_PC_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    rob_commit_ctrl_if.slave    bus,
    output logic [31:0]         commit_cnt_o,
    output logic [31:0]         stall_full_cnt_o
);

    localparam int IDX_BITS  = $clog2(QUEUE_SIZE);
    localparam int CNT_BITS  = IDX_BITS + 1;
    localparam int PREG_BITS = $clog2(NUM_P_REGS);

    rob_state_e            state_q, state_d;
    logic                  flush_q, flush_d;
    logic [PC_SIZE-1:0]    redirect_pc_q, redirect_pc_d;
    logic [IDX_BITS-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]   count_q, count_d;

    logic [IDX_BITS-1:0]   head1, tail1;
    rob_status_t           head_st0, head_st1;
    logic [QUEUE_SIZE-1:0] valid_vec;
    logic                  run, gnt0, gnt1, cmpl_ok0, cmpl_ok1;
    logic                  commit0, commit1, exc_at_head, bulk_clr;
    logic [1:0]            nalloc, ncommit;
    logic [PREG_BITS-1:0]  free_preg0, free_preg1;

    // Grant, completion filtering and commit selection for the current cycle.
    always_comb begin
        run   = (state_q == RUN);
        head1 = head_q + IDX_BITS'(1);
        tail1 = tail_q + IDX_BITS'(1);
        gnt0  = run & bus.alloc_req0_i & (count_q < CNT_BITS'(QUEUE_SIZE));
        gnt1  = run & bus.alloc_req1_i & gnt0 & (count_q < CNT_BITS'(QUEUE_SIZE - 1));
        // A completion aimed at a slot being allocated this cycle is stale; allocation wins.
        cmpl_ok0 = run & bus.cmpl_en0_i & valid_vec[bus.cmpl_idx0_i]
                 & ~(gnt0 & (bus.cmpl_idx0_i == tail_q))
                 & ~(gnt1 & (bus.cmpl_idx0_i == tail1));
        cmpl_ok1 = run & bus.cmpl_en1_i & valid_vec[bus.cmpl_idx1_i]
                 & ~(gnt0 & (bus.cmpl_idx1_i == tail_q))
                 & ~(gnt1 & (bus.cmpl_idx1_i == tail1));
        commit0 = run & bus.freelist_rdy_i & head_st0.valid & head_st0.complete & ~head_st0.exc;
        commit1 = commit0 & head_st1.valid & head_st1.complete & ~head_st1.exc;
        exc_at_head = run & head_st0.valid & head_st0.complete & head_st0.exc;
        nalloc   = count2(gnt0, gnt1);
        ncommit  = count2(commit0, commit1);
        bulk_clr = (state_q == FLUSH);
    end

    rob_status_array #(
        .QUEUE_SIZE (QUEUE_SIZE)
    ) u_status (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_we0_i  (gnt0),
        .alloc_idx0_i (tail_q),
        .alloc_we1_i  (gnt1),
        .alloc_idx1_i (tail1),
        .cmpl_we0_i   (cmpl_ok0),
        .cmpl_idx0_i  (bus.cmpl_idx0_i),
        .cmpl_exc0_i  (bus.cmpl_exc0_i),
        .cmpl_we1_i   (cmpl_ok1),
        .cmpl_idx1_i  (bus.cmpl_idx1_i),
        .cmpl_exc1_i  (bus.cmpl_exc1_i),
        .clr_we0_i    (commit0),
        .clr_idx0_i   (head_q),
        .clr_we1_i    (commit1),
        .clr_idx1_i   (head1),
        .bulk_clr_i   (bulk_clr),
        .rd_idx0_i    (head_q),
        .rd_idx1_i    (head1),
        .rd_st0_o     (head_st0),
        .rd_st1_o     (head_st1),
        .valid_vec_o  (valid_vec)
    );

    // Pointer and occupancy update; the end of a flush empties the queue.
    always_comb begin
        head_d  = head_q + IDX_BITS'(ncommit);
        tail_d  = tail_q + IDX_BITS'(nalloc);
        count_d = count_q + CNT_BITS'(nalloc) - CNT_BITS'(ncommit);
        if (state_q == FLUSH) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FSM next state: an excepting head starts a flush that always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (exc_at_head) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM outputs: flush pulse and faulting pc captured on the RUN->FLUSH edge.
    always_comb begin
        flush_d       = (state_q == RUN) & exc_at_head;
        redirect_pc_d = flush_d ? bus.rob_pc0_i : redirect_pc_q;
    end

    // FSM state and registered flush outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign free_preg0 = bus.rob_old_dest0_i;
    assign free_preg1 = bus.rob_old_dest1_i;

    assign bus.alloc_gnt0_o  = gnt0;
    assign bus.alloc_gnt1_o  = gnt1;
    assign bus.alloc_idx0_o  = tail_q;
    assign bus.alloc_idx1_o  = tail1;
    assign bus.rob_full_o    = (count_q > CNT_BITS'(QUEUE_SIZE - 2));
    assign bus.commit_idx0_o = head_q;
    assign bus.commit_idx1_o = head1;
    assign bus.commit_en0_o  = commit0;
    assign bus.commit_en1_o  = commit1;
    assign bus.free_en0_o    = commit0;
    assign bus.free_en1_o    = commit1;
    assign bus.free_preg0_o  = free_preg0;
    assign bus.free_preg1_o  = free_preg1;
    assign bus.flush_o       = flush_q;
    assign bus.redirect_pc_o = redirect_pc_q;

`ifdef ROB_PERF_CNT_EN
    logic [31:0] commit_cnt_q, commit_cnt_d, stall_cnt_q, stall_cnt_d;

    // Retired-instruction and dispatch-denied counters, free-running with natural wrap.
    always_comb begin
        commit_cnt_d = commit_cnt_q + 32'(ncommit);
        stall_cnt_d  = stall_cnt_q + 32'(run & bus.alloc_req0_i & ~gnt0);
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign commit_cnt_o     = commit_cnt_q;
    assign stall_full_cnt_o = stall_cnt_q;
`else
    assign commit_cnt_o     = '0;
    assign stall_full_cnt_o = '0;
`endif

endmodule
